run_sequencer: RTL
==================

# run_sequencer

Host-side sequencer for one processor run. It holds the processor at reset through `START`, preloads data memory from a byte stream, releases `START` and waits for `DONE`. It then streams a result window back out of data memory. It sits between the host/testbench link and the processor's `START`/`DONE` pins and data-memory port, driving the other end of the processor's run handshake.

## Interface
Parameters:
- `LOAD_BASE`, 8'd0: first data-memory address written during preload.
- `LOAD_LEN`, 9'd32: number of bytes preloaded (0..256; 0 skips preload).
- `RES_BASE`, 8'd64: first data-memory address of the result window.
- `RES_LEN`, 9'd4: number of result bytes streamed out (0..256; 0 skips readback).
- `TIMEOUT_CYC`, 16'hFFFF: maximum number of `RUN` cycles before the run is abandoned.

Ports:
- `CLK` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `go` in 1: level-sampled run request, honoured only in `IDLE`.
- `in_valid` in 1, `in_data` in 8, `in_ready` out 1: preload byte stream.
- `mem_own` out 1: sequencer owns the data-memory port; an external mux gives the processor the port when this is 0.
- `mem_addr` out 8, `mem_we` out 1, `mem_wdata` out 8, `mem_rdata` in 8: data-memory port. Read is asynchronous: `mem_rdata` follows `mem_addr` in the same cycle.
- `START` out 1: processor init/reset, active-high.
- `DONE` in 1: processor finished.
- `out_valid` out 1, `out_data` out 8, `out_ready` in 1: result byte stream.
- `busy` out 1, `run_done` out 1 (one-cycle pulse), `timeout` out 1 (sticky until next accepted `go`).
- `cycles` out 16: `RUN` cycle count of the last run.

## Operation
States are `IDLE`, `LOAD`, `RUN`, `READ` and `FINISH`.

- **`IDLE`**
  - `START`=1, `mem_own`=1, `busy`=0.
  - On `go`=1: clear `timeout`, `cycles` and the byte counter, then go to `LOAD`. If `LOAD_LEN`=0, go directly to `RUN`.
- **`LOAD`**
  - `START`=1, `in_ready`=1.
  - Each beat with `in_valid`: `mem_we`=1, `mem_addr`=`LOAD_BASE`+cnt (mod 256), `mem_wdata`=`in_data`, then cnt++.
  - After beat `LOAD_LEN`-1 is accepted: go to `RUN`, cnt=0.
- **`RUN`**
  - `START`=0, `mem_own`=0, `mem_we`=0.
  - The first `RUN` cycle masks `DONE`, because a stale `DONE` from the prior run may persist until the processor leaves init.
  - On any later cycle with `DONE`=1: go to `READ`, or to `FINISH` if `RES_LEN`=0.
  - Otherwise `cycles`++. When `cycles`==`TIMEOUT_CYC` with `DONE`=0: set `timeout`, go to `FINISH` with no readback.
- **`READ`**
  - `START`=1 (freezes the processor), `mem_own`=1.
  - `mem_addr`=`RES_BASE`+cnt (mod 256), `out_data`=`mem_rdata`, `out_valid`=1.
  - On `out_ready`: cnt++. After byte `RES_LEN`-1 is taken, go to `FINISH`.
- **`FINISH`**
  - `run_done`=1 for exactly one cycle, then go to `IDLE`.
- `busy`=1 in every state except `IDLE`.
- `go` is ignored while `busy`.
- `in_ready`=0 outside `LOAD`; `out_valid`=0 outside `READ`.
- Counters are 9-bit, so a length of 256 is legal. Address arithmetic wraps modulo 256.

## Timing
- Reset values: state `IDLE`, `START`=1, `mem_own`=1, `mem_we`=0, `in_ready`=0, `out_valid`=0, `out_data`=`mem_rdata` (don't-care), `busy`=0, `run_done`=0, `timeout`=0, `cycles`=0.
- `go` seen at edge k puts the block in `LOAD` from cycle k+1, so `in_ready`=1 in cycle k+1.
- The memory write happens at the same edge that accepts the beat. The last beat's edge enters `RUN`, so `START` falls in the following cycle. `LOAD` with no stalls lasts `LOAD_LEN` cycles.
- `DONE` is sampled from the second `RUN` cycle onward. `READ` starts the cycle after `DONE` is sampled high.
- `cycles` equals the number of `RUN` cycles with `DONE` unsampled or low, excluding the `DONE` cycle.
- `out_data` is stable whenever `out_valid`=1 and `out_ready`=0. Stalls hold the address.
- `reset` in any state immediately forces the reset values, including `START`=1 mid-`RUN`. Partial loads and reads are abandoned.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → all outputs take reset values at once, before the next edge.
- **Nominal run:** `LOAD_LEN`=4, bytes 11,22,33,44 → writes to addresses 0..3. `START` falls the cycle after the 4th beat. `DONE` after 10 `RUN` cycles → `cycles`=10 and results at addresses 64..67 streamed out. `run_done` pulses once.
- **Backpressure:** stall `in_valid` for 3 cycles mid-load and hold `out_ready`=0 for 5 cycles on byte 2 → no duplicate or lost writes, and `out_data` stays constant during the stall.
- **Stale DONE:** `DONE`=1 held across `go` and into the first `RUN` cycle, then low → not treated as completion. The run ends only on a later `DONE` rise.
- **Timeout:** `TIMEOUT_CYC`=20 with `DONE` stuck at 0 → `timeout`=1 and `cycles`=20, no readback, `run_done` pulse, `START`=1 afterwards. A second `go` clears `timeout`.
- **Edge cases:** `LOAD_LEN`=0, `RES_LEN`=0 → `go` goes straight to `RUN`, then `FINISH`. `LOAD_BASE`=8'hFE with `LOAD_LEN`=4 → addresses FE,FF,00,01. A second `go` while `busy` is ignored.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: host-side sequencer for a single processor run.
//
// Holds the processor in init (START=1) while a byte stream is preloaded
// into data memory, releases START and waits for DONE (or a cycle budget
// to expire), then streams a window of data memory back to the host.
//
// Ports
//   CLK, reset               clock, asynchronous active-high reset
//   go                       run request, honoured only while idle
//   in_valid/in_data/in_ready   preload byte stream (sink)
//   mem_own                  1: sequencer owns the data-memory port
//   mem_addr/mem_we/mem_wdata/mem_rdata   data-memory port (async read)
//   START, DONE              processor init/reset and completion pins
//   out_valid/out_data/out_ready   result byte stream (source)
//   busy, run_done, timeout  status: not idle, end-of-run pulse, sticky abandon flag
//   cycles                   RUN cycle count of the last run
module run_sequencer #(
    parameter logic [7:0]  LOAD_BASE   = 8'd0,
    parameter logic [8:0]  LOAD_LEN    = 9'd32,
    parameter logic [7:0]  RES_BASE    = 8'd64,
    parameter logic [8:0]  RES_LEN     = 9'd4,
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        go,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_own,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        START,
    input  logic        DONE,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        run_done,
    output logic        timeout,
    output logic [15:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_READ,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;        // byte index within LOAD or READ
    logic [15:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;
    logic        first_q, first_d;    // high only in the first RUN cycle

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 9'd0;
            cycles_q  <= 16'd0;
            timeout_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            first_q   <= first_d;
        end
    end

    // NOTE: every output and next-state value gets a default before the case
    // statement; a path that forgot one would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        first_d   = 1'b0;

        START     = 1'b1;
        mem_own   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = in_data;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = mem_rdata;
        busy      = 1'b1;
        run_done  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    timeout_d = 1'b0;
                    cycles_d  = 16'd0;
                    cnt_d     = 9'd0;
                    if (LOAD_LEN == 9'd0) begin
                        state_d = S_RUN;
                        first_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = LOAD_BASE + cnt_q[7:0];   // wraps modulo 256
                if (in_valid) begin
                    mem_we = 1'b1;
                    if (cnt_q == LOAD_LEN - 9'd1) begin
                        cnt_d   = 9'd0;
                        state_d = S_RUN;
                        first_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end

            S_RUN: begin
                START   = 1'b0;
                mem_own = 1'b0;
                // A DONE left over from the previous run can linger until the
                // processor leaves init, so the first RUN cycle ignores it.
                if (DONE && !first_q) begin
                    state_d = (RES_LEN == 9'd0) ? S_FINISH : S_READ;
                end else begin
                    cycles_d = cycles_q + 16'd1;
                    if (cycles_q + 16'd1 == TIMEOUT_CYC) begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end

            S_READ: begin
                mem_addr  = RES_BASE + cnt_q[7:0];   // held while stalled
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == RES_LEN - 9'd1) begin
                        cnt_d   = 9'd0;
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end

            S_FINISH: begin
                run_done = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign timeout = timeout_q;
    assign cycles  = cycles_q;

endmodule
